// File: rtl/hopfield_net_seq.sv
// Iterative Hopfield recall engine.
// Loads a bipolar probe vector, then sweeps the neurons one at a time. Each neuron's
// local field is accumulated LANES weight products per cycle. Sweeps repeat until a
// sweep changes nothing or MAX_ITER sweeps have run.
// Neuron states are held internally as one sign bit each (1 = -1).
// They are expanded to SIZE-bit +1 / -1 words only on fullres.
//
// Control is a level-based run request rather than a handshake:
//   - en high in IDLE starts a run.
//   - en must stay high until done.
//   - Dropping en in any busy state aborts to IDLE.
//   - Dropping en in DONE releases the result and clears done.
module hopfield_net_seq #(
  parameter int N        = 81,
  parameter int SIZE     = 16,
  parameter int LANES    = 1,
  parameter int MAX_ITER = 16,
  parameter int SYNC     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [N*SIZE-1:0]              S,
  input  logic [SIZE*N*N-1:0]            W,
  output logic [N*SIZE-1:0]              fullres,
  output logic                           done,
  output logic                           timeout,
  output logic [$clog2(MAX_ITER+1)-1:0]  iter_cnt
);

  localparam int CHUNKS = (N + LANES - 1) / LANES;
  localparam int PADN   = CHUNKS * LANES;
  localparam int PADW   = PADN * SIZE;
  localparam int ROWW   = N * SIZE;
  localparam int CHW    = LANES * SIZE;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int AW     = SIZE + $clog2(N) + 1;
  localparam int ITW    = $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_UPDATE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Current FSM state; kept as a named typed signal so checkers can bind to it.
  state_t              state;
  logic [IW-1:0]       nidx;       // neuron being updated
  logic [CW-1:0]       cidx;       // lane group within the current row
  logic signed [AW-1:0] acc;       // local field of neuron nidx
  logic [N-1:0]        live_neg;   // live state, 1 = -1
  logic [N-1:0]        next_neg;   // next-sweep buffer, used only when SYNC != 0
  logic                changed;    // some neuron flipped during this sweep
  logic                loaded;     // a probe has been latched since reset

  logic [ROWW-1:0]      row_w;
  logic [PADW-1:0]      row_pad;
  logic [PADN-1:0]      sgn_pad;
  logic [CHW-1:0]       chunk_w;
  logic [LANES-1:0]     chunk_s;
  logic signed [SIZE-1:0] lane_w;
  logic signed [AW-1:0] lane_x;
  logic signed [AW-1:0] chunk_sum;

  logic old_neg;
  logic new_neg;
  logic h_pos;
  logic h_neg;

  // Select one lane group of the current weight row and sum its signed terms.
  // The row and state vectors are zero-padded to whole lane groups.
  // Lanes past neuron N-1 therefore see a zero weight and add nothing.
  // In synchronous mode the live state is frozen during a sweep, so it doubles as
  // the previous-sweep snapshot.
  always_comb begin
    row_w     = ROWW'(W >> (nidx * ROWW));
    row_pad   = PADW'(row_w);
    sgn_pad   = PADN'(live_neg);
    chunk_w   = CHW'(row_pad >> (cidx * CHW));
    chunk_s   = LANES'(sgn_pad >> (cidx * LANES));
    chunk_sum = '0;
    lane_w    = '0;
    lane_x    = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_w    = chunk_w[l*SIZE +: SIZE];
      lane_x    = {{(AW-SIZE){lane_w[SIZE-1]}}, lane_w};
      chunk_sum = chunk_s[l] ? (chunk_sum - lane_x) : (chunk_sum + lane_x);
    end
  end

  // Threshold the accumulated field.
  // Zero field keeps the neuron's previous value.
  always_comb begin
    old_neg = live_neg[nidx];
    h_neg   = acc[AW-1];
    h_pos   = !acc[AW-1] && (acc != '0);
    new_neg = h_pos ? 1'b0 : (h_neg ? 1'b1 : old_neg);
  end

  // Expand the sign-bit state into +1 / -1 words.
  // Output is zero until the first probe is loaded.
  always_comb begin
    fullres = '0;
    for (int i = 0; i < N; i++) begin
      if (loaded) begin
        fullres[i*SIZE +: SIZE] = live_neg[i] ? {SIZE{1'b1}} : SIZE'(1);
      end
    end
  end

  // Recall sequencer: load, per-neuron accumulate/update, end-of-sweep check, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      nidx     <= '0;
      cidx     <= '0;
      acc      <= '0;
      live_neg <= '0;
      next_neg <= '0;
      changed  <= 1'b0;
      loaded   <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      iter_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (en) begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            for (int i = 0; i < N; i++) begin
              live_neg[i] <= S[i*SIZE + SIZE - 1];
              next_neg[i] <= S[i*SIZE + SIZE - 1];
            end
            loaded   <= 1'b1;
            iter_cnt <= '0;
            timeout  <= 1'b0;
            changed  <= 1'b0;
            nidx     <= '0;
            cidx     <= '0;
            acc      <= '0;
            state    <= ST_CALC;
          end
        end

        ST_CALC: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc + chunk_sum;
            if (cidx == CW'(CHUNKS - 1)) begin
              cidx  <= '0;
              state <= ST_UPDATE;
            end else begin
              cidx <= cidx + CW'(1);
            end
          end
        end

        ST_UPDATE: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            if (SYNC != 0) begin
              next_neg[nidx] <= new_neg;
            end else begin
              live_neg[nidx] <= new_neg;
            end
            if (new_neg != old_neg) begin
              changed <= 1'b1;
            end
            acc <= '0;
            if (nidx == IW'(N - 1)) begin
              state <= ST_CHECK;
            end else begin
              nidx  <= nidx + IW'(1);
              state <= ST_CALC;
            end
          end
        end

        ST_CHECK: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            iter_cnt <= iter_cnt + ITW'(1);
            if (SYNC != 0) begin
              live_neg <= next_neg;
            end
            nidx <= '0;
            cidx <= '0;
            acc  <= '0;
            if (!changed) begin
              state <= ST_DONE;
            end else if (iter_cnt == ITW'(MAX_ITER - 1)) begin
              timeout <= 1'b1;
              state   <= ST_DONE;
            end else begin
              changed <= 1'b0;
              state   <= ST_CALC;
            end
          end
        end

        ST_DONE: begin
          if (!en) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
